dram_cmd_scheduler: RTL and testbench

//  Sits between the trace parser and the DRAM command output. Buffers parsed
//  ops in an in-order request queue and decodes each address into bank group,

---
 rtl/dram_cmd_scheduler_pkg.sv | 59 +++++
 rtl/dram_cmd_scheduler_req_queue.sv | 54 +++++
 rtl/dram_cmd_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_dram_cmd_scheduler.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_cmd_scheduler_pkg.sv
// rtl/dram_cmd_scheduler_pkg.sv - shared types, address map and widths for the DRAM command scheduler
package dram_cmd_scheduler_pkg;

    localparam int ADDRESS_WIDTH = 32;

    // Byte address map: [31:17] row, [16:15] bank group, [14:13] bank, [12:3] column, [2:0] byte
    localparam int COL_LSB  = 3;
    localparam int COL_MSB  = 12;
    localparam int BANK_LSB = 13;
    localparam int BANK_MSB = 14;
    localparam int BG_LSB   = 15;
    localparam int BG_MSB   = 16;
    localparam int ROW_LSB  = 17;
    localparam int ROW_MSB  = 31;

    localparam int COL_W     = COL_MSB - COL_LSB + 1;
    localparam int BANK_W    = BANK_MSB - BANK_LSB + 1;
    localparam int BG_W      = BG_MSB - BG_LSB + 1;
    localparam int ROW_W     = ROW_MSB - ROW_LSB + 1;
    localparam int NUM_BANKS = 1 << (BG_W + BANK_W);

    // Wide enough for the longest wait (tCL + tBURST) and tRAS
    localparam int TIMER_W = 8;

    typedef enum logic [1:0] {
        NOP    = 2'd0,
        READ   = 2'd1,
        WRITE  = 2'd2,
        IFETCH = 2'd3
    } parsed_op_t;

    typedef enum logic [2:0] {
        CMD_NONE = 3'd0,
        CMD_PRE  = 3'd1,
        CMD_ACT  = 3'd2,
        CMD_RD   = 3'd3,
        CMD_WR   = 3'd4
    } dram_cmd_t;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DECODE    = 3'd1,
        S_PRE       = 3'd2,
        S_WAIT_RP   = 3'd3,
        S_ACT       = 3'd4,
        S_WAIT_RCD  = 3'd5,
        S_COL       = 3'd6,
        S_WAIT_DATA = 3'd7
    } sched_states_t;

    // Queue entry is {opcode, address}
    localparam int REQ_W = $bits(parsed_op_t) + ADDRESS_WIDTH;

    // Column command for a queued op; instruction fetches are reads
    function automatic dram_cmd_t col_cmd(input parsed_op_t op);
        return (op == WRITE) ? CMD_WR : CMD_RD;
    endfunction

endpackage

// File: rtl/dram_cmd_scheduler_req_queue.sv
// rtl/dram_cmd_scheduler_req_queue.sv - in-order circular request FIFO
module dram_cmd_scheduler_req_queue #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 34
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head_data
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              do_push;
    logic              do_pop;

    // Full is taken from the registered count, so a same-cycle pop never frees room for a push
    assign full      = (count == (PTR_W + 1)'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/dram_cmd_scheduler.sv
// rtl/dram_cmd_scheduler.sv - open-page PRE/ACT/RD/WR scheduler; SCHED_CMD_LOG_EN adds a command log
module dram_cmd_scheduler
    import dram_cmd_scheduler_pkg::*;
#(
    parameter int QUEUE_DEPTH = 16,
    parameter int T_RCD       = 48,
    parameter int T_RP        = 48,
    parameter int T_CL        = 48,
    parameter int T_BURST     = 8,
    parameter int T_RAS       = 104
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     op_ready_s,
    input  parsed_op_t               opcode,
    input  logic [ADDRESS_WIDTH-1:0] address,
    output logic                     q_full,
    output logic                     q_overflow,
    output logic                     cmd_valid,
    output dram_cmd_t                cmd,
    output logic [BG_W-1:0]          cmd_bg,
    output logic [BANK_W-1:0]        cmd_bank,
    output logic [ROW_W-1:0]         cmd_row,
    output logic [COL_W-1:0]         cmd_col,
    output sched_states_t            state
);

    localparam int BIDX_W = BG_W + BANK_W;

    logic [REQ_W-1:0]         head_bits;
    logic                     q_empty;
    logic                     push;
    logic                     pop;
    parsed_op_t               head_op;
    logic [ADDRESS_WIDTH-1:0] head_addr;
    logic [BG_W-1:0]          head_bg;
    logic [BANK_W-1:0]        head_bank;
    logic [ROW_W-1:0]         head_row;
    logic [COL_W-1:0]         head_col;
    logic [BIDX_W-1:0]        head_idx;
    logic                     unused_addr_bits;

    sched_states_t            state_next;
    logic                     pre_fire;
    logic [TIMER_W-1:0]       timer;
    logic [NUM_BANKS-1:0]     bank_open;
    logic [ROW_W-1:0]         open_row [NUM_BANKS];
    logic [TIMER_W-1:0]       tras_cnt [NUM_BANKS];

    assign push = op_ready_s && !q_full && (opcode != NOP);
    assign pop  = (state == S_WAIT_DATA) && (timer == '0);

    dram_cmd_scheduler_req_queue #(
        .DEPTH  (QUEUE_DEPTH),
        .DATA_W (REQ_W)
    ) u_req_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data ({opcode, address}),
        .full      (q_full),
        .empty     (q_empty),
        .head_data (head_bits)
    );

    // Head-of-queue decode; the head is stable for the whole life of a request
    assign head_op          = parsed_op_t'(head_bits[REQ_W-1:ADDRESS_WIDTH]);
    assign head_addr        = head_bits[ADDRESS_WIDTH-1:0];
    assign head_bg          = head_addr[BG_MSB:BG_LSB];
    assign head_bank        = head_addr[BANK_MSB:BANK_LSB];
    assign head_row         = head_addr[ROW_MSB:ROW_LSB];
    assign head_col         = head_addr[COL_MSB:COL_LSB];
    assign head_idx         = {head_bg, head_bank};
    assign unused_addr_bits = ^head_addr[COL_LSB-1:0];

    // Sticky overflow: any strobe seen while the queue is full
    always_ff @(posedge clk) begin
        if (rst)                      q_overflow <= 1'b0;
        else if (op_ready_s && q_full) q_overflow <= 1'b1;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next state; PRE is fired on the edge that makes the bank's tRAS counter read zero in S_PRE
    always_comb begin
        state_next = state;
        pre_fire   = 1'b0;
        case (state)
            S_IDLE:      if (!q_empty) state_next = S_DECODE;
            S_DECODE: begin
                if (!bank_open[head_idx])                state_next = S_ACT;
                else if (open_row[head_idx] == head_row) state_next = S_COL;
                else                                     state_next = S_PRE;
            end
            S_PRE:       if (tras_cnt[head_idx] == '0) state_next = S_WAIT_RP;
            S_WAIT_RP:   if (timer == '0) state_next = S_ACT;
            S_ACT:       state_next = S_WAIT_RCD;
            S_WAIT_RCD:  if (timer == '0) state_next = S_COL;
            S_COL:       state_next = S_WAIT_DATA;
            S_WAIT_DATA: if (timer == '0) state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
        if ((state_next == S_PRE) && (tras_cnt[head_idx] <= TIMER_W'(1))) pre_fire = 1'b1;
    end

    // Command outputs, registered alongside the issuing state
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_valid <= 1'b0;
            cmd       <= CMD_NONE;
            cmd_bg    <= '0;
            cmd_bank  <= '0;
            cmd_row   <= '0;
            cmd_col   <= '0;
        end else begin
            cmd_valid <= 1'b0;
            cmd       <= CMD_NONE;
            cmd_bg    <= '0;
            cmd_bank  <= '0;
            cmd_row   <= '0;
            cmd_col   <= '0;
            if (state_next == S_ACT) begin
                cmd_valid <= 1'b1;
                cmd       <= CMD_ACT;
                cmd_bg    <= head_bg;
                cmd_bank  <= head_bank;
                cmd_row   <= head_row;
            end else if (state_next == S_COL) begin
                cmd_valid <= 1'b1;
                cmd       <= col_cmd(head_op);
                cmd_bg    <= head_bg;
                cmd_bank  <= head_bank;
                cmd_col   <= head_col;
            end else if (pre_fire) begin
                cmd_valid <= 1'b1;
                cmd       <= CMD_PRE;
                cmd_bg    <= head_bg;
                cmd_bank  <= head_bank;
            end
        end
    end

    // Shared wait timer, loaded with the command so the wait state exits exactly on the boundary
    always_ff @(posedge clk) begin
        if (rst)                        timer <= '0;
        else if (state_next == S_ACT)   timer <= TIMER_W'(T_RCD - 1);
        else if (state_next == S_COL)   timer <= TIMER_W'(T_CL + T_BURST - 1);
        else if (pre_fire)              timer <= TIMER_W'(T_RP - 1);
        else if (timer != '0)           timer <= timer - 1'b1;
    end

    // Bank table: open row per bank and a saturating tRAS counter started by each ACT
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_open <= '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                open_row[b] <= '0;
                tras_cnt[b] <= '0;
            end
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if ((state == S_ACT) && (head_idx == BIDX_W'(b))) tras_cnt[b] <= TIMER_W'(T_RAS - 1);
                else if (tras_cnt[b] != '0)                       tras_cnt[b] <= tras_cnt[b] - 1'b1;
            end
            if (state == S_ACT) begin
                bank_open[head_idx] <= 1'b1;
                open_row[head_idx]  <= head_row;
            end else if ((state == S_PRE) && (tras_cnt[head_idx] == '0)) begin
                bank_open[head_idx] <= 1'b0;
            end
        end
    end

`ifdef SCHED_CMD_LOG_EN
    logic [31:0] clk_count;

    // Free-running cycle stamp for the command log
    always_ff @(posedge clk) begin
        if (rst) clk_count <= '0;
        else     clk_count <= clk_count + 1'b1;
    end

    // One log line per presented command: row for ACT, column otherwise
    always_ff @(posedge clk) begin
        if (!rst && cmd_valid)
            $display("%0d %s %0d %0d %0d", clk_count, cmd.name(), cmd_bg, cmd_bank,
                     (cmd == CMD_ACT) ? 32'(cmd_row) : 32'(cmd_col));
    end
`endif

endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// tb/tb_dram_cmd_scheduler.sv - directed self-checking bench for dram_cmd_scheduler
module tb_dram_cmd_scheduler;
    import dram_cmd_scheduler_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     op_ready_s = 1'b0;
    parsed_op_t               opcode = NOP;
    logic [ADDRESS_WIDTH-1:0] address = '0;
    logic                     q_full;
    logic                     q_overflow;
    logic                     cmd_valid;
    dram_cmd_t                cmd;
    logic [BG_W-1:0]          cmd_bg;
    logic [BANK_W-1:0]        cmd_bank;
    logic [ROW_W-1:0]         cmd_row;
    logic [COL_W-1:0]         cmd_col;
    sched_states_t            state;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    dram_cmd_t         c_cmd;
    logic [BG_W-1:0]   c_bg;
    logic [BANK_W-1:0] c_bank;
    logic [ROW_W-1:0]  c_row;
    logic [COL_W-1:0]  c_col;
    int                c_t;

    typedef struct {
        parsed_op_t  op;
        logic [31:0] addr;
        bit          pre;
        bit          act;
        dram_cmd_t   ccmd;
        logic [1:0]  bg;
        logic [1:0]  bank;
        logic [14:0] row;
        logic [9:0]  col;
    } vec_t;

    vec_t vecs [6];

    dram_cmd_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .op_ready_s (op_ready_s),
        .opcode     (opcode),
        .address    (address),
        .q_full     (q_full),
        .q_overflow (q_overflow),
        .cmd_valid  (cmd_valid),
        .cmd        (cmd),
        .cmd_bg     (cmd_bg),
        .cmd_bank   (cmd_bank),
        .cmd_row    (cmd_row),
        .cmd_col    (cmd_col),
        .state      (state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic push(input parsed_op_t op, input logic [31:0] a);
        @(negedge clk);
        op_ready_s = 1'b1;
        opcode     = op;
        address    = a;
        @(negedge clk);
        op_ready_s = 1'b0;
        opcode     = NOP;
    endtask

    task automatic wait_cmd(input int limit, output bit got);
        got = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (cmd_valid) begin
                got    = 1'b1;
                c_cmd  = cmd;
                c_bg   = cmd_bg;
                c_bank = cmd_bank;
                c_row  = cmd_row;
                c_col  = cmd_col;
                c_t    = cyc;
                break;
            end
        end
    endtask

    task automatic expect_cmd(input string nm, input dram_cmd_t ec, input logic [1:0] ebg,
                              input logic [1:0] ebank, input logic [14:0] erow, input logic [9:0] ecol);
        bit got;
        wait_cmd(200, got);
        chk({nm, "_seen"}, 32'(got), 32'd1);
        if (got) begin
            chk({nm, "_cmd"},  32'(c_cmd),  32'(ec));
            chk({nm, "_bg"},   32'(c_bg),   32'(ebg));
            chk({nm, "_bank"}, 32'(c_bank), 32'(ebank));
            chk({nm, "_row"},  32'(c_row),  32'(erow));
            chk({nm, "_col"},  32'(c_col),  32'(ecol));
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int p;
        int t_pre;
        int t_act;
        int t_col;
        string pf;
        pf = $sformatf("v%0d", idx);
        t_pre = 0;
        t_act = 0;
        push(v.op, v.addr);
        p = cyc;
        if (v.pre) begin
            expect_cmd({pf, "_pre"}, CMD_PRE, v.bg, v.bank, 15'd0, 10'd0);
            chk({pf, "_pre_lat"}, c_t, p + 2);
            t_pre = c_t;
        end
        if (v.act) begin
            expect_cmd({pf, "_act"}, CMD_ACT, v.bg, v.bank, v.row, 10'd0);
            chk({pf, "_act_lat"}, c_t, v.pre ? t_pre + 48 : p + 2);
            t_act = c_t;
        end
        expect_cmd({pf, "_col"}, v.ccmd, v.bg, v.bank, 15'd0, v.col);
        chk({pf, "_col_lat"}, c_t, v.act ? t_act + 48 : p + 2);
        t_col = c_t;
        while (cyc < t_col + 55) @(negedge clk);
        chk({pf, "_wait_data"}, 32'(state), 32'(S_WAIT_DATA));
        @(negedge clk);
        chk({pf, "_idle_after_pop"}, 32'(state), 32'(S_IDLE));
    endtask

    initial begin
        int p;
        int t_a;
        int t_r;
        int t_p;
        int n_act;
        int n_col;
        int n_oth;

        vecs[0] = '{READ,   32'h000A_C085, 1'b0, 1'b1, CMD_RD, 2'd1, 2'd2, 15'h0005, 10'h010};
        vecs[1] = '{READ,   32'h000A_DFF8, 1'b0, 1'b0, CMD_RD, 2'd1, 2'd2, 15'h0005, 10'h3FF};
        vecs[2] = '{WRITE,  32'hFFFE_C000, 1'b1, 1'b1, CMD_WR, 2'd1, 2'd2, 15'h7FFF, 10'h000};
        vecs[3] = '{IFETCH, 32'h0001_E008, 1'b0, 1'b1, CMD_RD, 2'd3, 2'd3, 15'h0000, 10'h001};
        vecs[4] = '{WRITE,  32'h0246_1550, 1'b0, 1'b1, CMD_WR, 2'd0, 2'd0, 15'h0123, 10'h2AA};
        vecs[5] = '{READ,   32'h0001_E010, 1'b0, 1'b0, CMD_RD, 2'd3, 2'd3, 15'h0000, 10'h002};

        // Reset state
        do_reset();
        chk("rst_q_full",    32'(q_full),     32'd0);
        chk("rst_q_overflow", 32'(q_overflow), 32'd0);
        chk("rst_cmd_valid", 32'(cmd_valid),  32'd0);
        chk("rst_cmd",       32'(cmd),        32'(CMD_NONE));
        chk("rst_fields",    {cmd_bg, cmd_bank, cmd_row, cmd_col}, 32'd0);
        chk("rst_state",     32'(state),      32'(S_IDLE));

        // Table: miss, hit, conflict, closed banks, hit on another bank
        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Back-to-back same-row reads: second RD two cycles after the first pop
        do_reset();
        @(negedge clk);
        op_ready_s = 1'b1; opcode = READ; address = 32'h0002_2020;
        @(negedge clk);
        address = 32'h0002_2048;
        @(negedge clk);
        op_ready_s = 1'b0; opcode = NOP;
        expect_cmd("b2b_act", CMD_ACT, 2'd0, 2'd1, 15'd1, 10'd0);
        t_a = c_t;
        expect_cmd("b2b_rd1", CMD_RD, 2'd0, 2'd1, 15'd0, 10'd4);
        chk("b2b_rd1_lat", c_t, t_a + 48);
        t_r = c_t;
        expect_cmd("b2b_rd2", CMD_RD, 2'd0, 2'd1, 15'd0, 10'd9);
        chk("b2b_rd2_lat", c_t, t_r + 58);
        repeat (60) @(negedge clk);

        // Row conflict right after ACT: PRE held off by tRAS
        do_reset();
        @(negedge clk);
        op_ready_s = 1'b1; opcode = READ; address = 32'h0002_2020;
        @(negedge clk);
        address = 32'h0004_2028;
        @(negedge clk);
        op_ready_s = 1'b0; opcode = NOP;
        expect_cmd("cf_act1", CMD_ACT, 2'd0, 2'd1, 15'd1, 10'd0);
        t_a = c_t;
        expect_cmd("cf_rd1", CMD_RD, 2'd0, 2'd1, 15'd0, 10'd4);
        chk("cf_rd1_lat", c_t, t_a + 48);
        expect_cmd("cf_pre", CMD_PRE, 2'd0, 2'd1, 15'd0, 10'd0);
        chk("cf_pre_after_tras", 32'(c_t >= t_a + 104), 32'd1);
        t_p = c_t;
        expect_cmd("cf_act2", CMD_ACT, 2'd0, 2'd1, 15'd2, 10'd0);
        chk("cf_act2_lat", c_t, t_p + 48);
        t_a = c_t;
        expect_cmd("cf_rd2", CMD_RD, 2'd0, 2'd1, 15'd0, 10'd5);
        chk("cf_rd2_lat", c_t, t_a + 48);
        repeat (60) @(negedge clk);

        // Seventeen strobes with no draining
        do_reset();
        n_act = 0; n_col = 0; n_oth = 0;
        @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            op_ready_s = 1'b1; opcode = READ; address = 32'h0002_2020 + 32'(i * 8);
            @(negedge clk);
            if (cmd_valid) begin
                if (cmd == CMD_ACT) n_act++;
                else if (cmd == CMD_RD) n_col++;
                else n_oth++;
            end
            if (i == 14) chk("ov_not_full_15", 32'(q_full), 32'd0);
            if (i == 15) begin
                chk("ov_full_16", 32'(q_full), 32'd1);
                chk("ov_no_overflow_16", 32'(q_overflow), 32'd0);
            end
            if (i == 16) begin
                chk("ov_full_17", 32'(q_full), 32'd1);
                chk("ov_overflow_17", 32'(q_overflow), 32'd1);
            end
        end
        op_ready_s = 1'b0; opcode = NOP;
        repeat (1200) begin
            @(negedge clk);
            if (cmd_valid) begin
                if (cmd == CMD_ACT) n_act++;
                else if (cmd == CMD_RD) n_col++;
                else n_oth++;
            end
        end
        chk("ov_act_count",   n_act, 1);
        chk("ov_col_count",   n_col, 16);
        chk("ov_other_count", n_oth, 0);
        chk("ov_drained",     32'(q_full), 32'd0);
        chk("ov_sticky",      32'(q_overflow), 32'd1);
        chk("ov_idle",        32'(state), 32'(S_IDLE));

        // Reset while waiting for tRCD
        do_reset();
        chk("mr_overflow_cleared", 32'(q_overflow), 32'd0);
        push(READ, 32'h0002_2020);
        expect_cmd("mr_act", CMD_ACT, 2'd0, 2'd1, 15'd1, 10'd0);
        repeat (10) @(negedge clk);
        chk("mr_in_rcd", 32'(state), 32'(S_WAIT_RCD));
        rst = 1'b1;
        @(negedge clk);
        chk("mr_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("mr_cmd",       32'(cmd),       32'(CMD_NONE));
        chk("mr_state",     32'(state),     32'(S_IDLE));
        chk("mr_q_full",    32'(q_full),    32'd0);
        rst = 1'b0;
        n_oth = 0;
        repeat (80) begin
            @(negedge clk);
            if (cmd_valid) n_oth++;
        end
        chk("mr_quiet", n_oth, 0);
        push(READ, 32'h0002_2020);
        p = cyc;
        expect_cmd("mr_react", CMD_ACT, 2'd0, 2'd1, 15'd1, 10'd0);
        chk("mr_react_lat", c_t, p + 2);
        expect_cmd("mr_rd", CMD_RD, 2'd0, 2'd1, 15'd0, 10'd4);
        repeat (60) @(negedge clk);

        // WRITE between NOPs: only the WRITE is queued
        do_reset();
        @(negedge clk);
        op_ready_s = 1'b1; opcode = NOP;   address = 32'h0004_2028;
        @(negedge clk);
        opcode = WRITE; address = 32'h0002_2020;
        @(negedge clk);
        opcode = NOP;   address = 32'h0004_2028;
        @(negedge clk);
        op_ready_s = 1'b0;
        expect_cmd("nw_act", CMD_ACT, 2'd0, 2'd1, 15'd1, 10'd0);
        expect_cmd("nw_wr",  CMD_WR,  2'd0, 2'd1, 15'd0, 10'd4);
        n_oth = 0;
        repeat (150) begin
            @(negedge clk);
            if (cmd_valid) n_oth++;
        end
        chk("nw_no_extra", n_oth, 0);
        chk("nw_idle", 32'(state), 32'(S_IDLE));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
